truth_table_sweeper: RTL

//  Reads back the function of a synthesized gate netlist (e.g. a Cello logic

---
 rtl/truth_table_sweeper.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose:
//   Reads back the logic function of a gate netlist wrapped by this block
//   (the circuit under test, CUT). Every input combination is driven in turn.
//   After a settle time the single CUT output is sampled into a truth table,
//   and the result is compared against an expected Cello hex code.
//   Row r of the sweep lands in bit (2**N_IN-1-r), so the assembled word reads
//   exactly like the hex code in a Cello module name (e.g. m0x0304 -> 16'h0304).
//
// Parameters:
//   N_IN           number of CUT inputs (table width = 2**N_IN)
//   SETTLE_CYCLES  wait cycles per row between drive and sample (0 allowed)
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      synchronous active-high reset; aborts a sweep with no done pulse
//   i_start    one-cycle sweep request, honoured only while idle
//   i_exp_tt   expected hex code, captured on the accepted start
//   o_cut_in   vector to the CUT (bit N_IN-1 = in1 ... bit 0 = inN)
//   i_cut_out  CUT output
//   o_busy     high from the cycle after the accepted start until done
//   o_done     one-cycle pulse; o_tt and o_match are valid from this cycle
//   o_tt       measured truth table, held until the next accepted start
//   o_match    o_tt equals the captured expected code
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [2**N_IN-1:0]   i_exp_tt,
    output logic [N_IN-1:0]      o_cut_in,
    input  logic                 i_cut_out,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2**N_IN-1:0]   o_tt,
    output logic                 o_match
);

    localparam int TT_W   = 2**N_IN;
    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // Row counter is one bit wider than the CUT input so the last-row compare
    // is never confused by wrap-around.
    localparam logic [N_IN:0]     ROW_LAST  = (N_IN+1)'(TT_W - 1);
    localparam logic [N_IN:0]     ROW_ZERO  = (N_IN+1)'(0);
    localparam logic [N_IN:0]     ROW_ONE   = (N_IN+1)'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [TT_W-1:0]   TT_ZERO   = TT_W'(0);
    localparam logic [N_IN-1:0]   CUT_ZERO  = N_IN'(0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t              r_state;
    logic [N_IN:0]       r_row;
    logic [WAIT_W-1:0]   r_wait;
    logic [N_IN-1:0]     r_cut_in;
    logic [TT_W-1:0]     r_tt;
    logic [TT_W-1:0]     r_exp_tt;
    logic                r_busy;
    logic                r_done;
    logic                r_match;

    logic [N_IN-1:0]     w_bit_idx;
    logic [TT_W-1:0]     w_tt_sampled;

    // Table with the current row's sample merged in. For an N_IN-bit row r,
    // (2**N_IN-1-r) is simply ~r, which places row 0 in the MSB.
    always_comb begin
        w_bit_idx               = ~r_row[N_IN-1:0];
        w_tt_sampled            = r_tt;
        w_tt_sampled[w_bit_idx] = i_cut_out;
    end

    // Sweep sequencer: drive row, settle, sample, repeat, then report.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_row    <= ROW_ZERO;
            r_wait   <= WAIT_ZERO;
            r_cut_in <= CUT_ZERO;
            r_tt     <= TT_ZERO;
            r_exp_tt <= TT_ZERO;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_match  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_exp_tt <= i_exp_tt;
                        r_row    <= ROW_ZERO;
                        r_tt     <= TT_ZERO;
                        r_busy   <= 1'b1;
                        r_state  <= S_DRIVE;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    r_cut_in <= r_row[N_IN-1:0];
                    r_wait   <= WAIT_ZERO;
                    r_state  <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_WAIT;
                end
                S_WAIT: begin
                    r_wait <= r_wait + WAIT_ONE;
                    if (r_wait == WAIT_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_SAMPLE: begin
                    r_tt <= w_tt_sampled;
                    if (r_row == ROW_LAST) begin
                        // done, match and busy are registered on entry to
                        // FINISH so they are all visible in the FINISH cycle;
                        // match therefore uses the table including this sample.
                        r_done  <= 1'b1;
                        r_match <= (w_tt_sampled == r_exp_tt);
                        r_busy  <= 1'b0;
                        r_state <= S_FINISH;
                    end else begin
                        r_row   <= r_row + ROW_ONE;
                        r_state <= S_DRIVE;
                    end
                end
                S_FINISH: begin
                    // start in this cycle is deliberately ignored
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cut_in = r_cut_in;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_tt     = r_tt;
    assign o_match  = r_match;

endmodule
